// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, PSR bit positions,
// control FSM states and iteration-unit operation select.
package alu_pkg;

  localparam logic [7:0] OP_ADD    = 8'h00;
  localparam logic [7:0] OP_ADDI   = 8'h01;
  localparam logic [7:0] OP_ADDU   = 8'h02;
  localparam logic [7:0] OP_ADDUI  = 8'h03;
  localparam logic [7:0] OP_ADDC   = 8'h04;
  localparam logic [7:0] OP_ADDCI  = 8'h05;
  localparam logic [7:0] OP_ADDCU  = 8'h06;
  localparam logic [7:0] OP_ADDCUI = 8'h07;
  localparam logic [7:0] OP_SUB    = 8'h08;
  localparam logic [7:0] OP_SUBI   = 8'h09;
  localparam logic [7:0] OP_CMP    = 8'h0A;
  localparam logic [7:0] OP_CMPI   = 8'h0B;
  localparam logic [7:0] OP_CMPU   = 8'h0C;
  localparam logic [7:0] OP_AND    = 8'h0D;
  localparam logic [7:0] OP_OR     = 8'h0E;
  localparam logic [7:0] OP_XOR    = 8'h0F;
  localparam logic [7:0] OP_NOT    = 8'h10;
  localparam logic [7:0] OP_LSH    = 8'h11;
  localparam logic [7:0] OP_LSHI   = 8'h12;
  localparam logic [7:0] OP_RSH    = 8'h13;
  localparam logic [7:0] OP_RSHI   = 8'h14;
  localparam logic [7:0] OP_ALSH   = 8'h15;
  localparam logic [7:0] OP_ARSH   = 8'h16;
  localparam logic [7:0] OP_NOP    = 8'h17;
  localparam logic [7:0] OP_MUL    = 8'h18;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {IDLE, ITER} state_e;

  typedef enum logic [1:0] {IT_SHL, IT_SHR, IT_SAR, IT_MUL} iter_op_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between decode (master) and the sequential ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (
    output in_valid, opcode, a, b,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, opcode, a, b,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Serial one-bit-per-cycle shifter and shift-add multiplier with step counter.
// done flags the final step; result/high_nz are the values after that step.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  iter_op_e         op,
  input  logic [SHW-1:0]   amount,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             high_nz
);

  iter_op_e         op_r;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH:0]   psum;

  // MUL keeps the product in {hi, lo}; the multiplier shifts out of lo as
  // partial-sum bits shift in from hi.
  always_comb begin
    psum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    lo_nx = lo;
    hi_nx = hi;
    case (op_r)
      IT_SHL: lo_nx = {lo[WIDTH-2:0], 1'b0};
      IT_SHR: lo_nx = {1'b0, lo[WIDTH-1:1]};
      IT_SAR: lo_nx = {lo[WIDTH-1], lo[WIDTH-1:1]};
      IT_MUL: begin
        hi_nx = psum[WIDTH:1];
        lo_nx = {psum[0], lo[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  assign done    = (cnt == SHW'(1));
  assign result  = lo_nx;
  assign high_nz = |hi_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= IT_SHL;
      cnt   <= '0;
      lo    <= '0;
      hi    <= '0;
      mcand <= '0;
    end else if (load) begin
      op_r <= op;
      cnt  <= amount;
      hi   <= '0;
      if (op == IT_MUL) begin
        lo    <= b;
        mcand <= a;
      end else begin
        lo    <= a;
        mcand <= '0;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - SHW'(1);
      lo  <= lo_nx;
      hi  <= hi_nx;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle ops registered at accept, shifts and MUL run in
// the iteration unit; PSR flags persist across operations.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  state_e           state;
  state_e           state_nx;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] res_nx;
  logic [4:0]       flags_r;
  logic [4:0]       flg_nx;
  logic [4:0]       mul_flags;
  logic             out_valid_r;
  logic             mul_pend;
  logic             accept;
  logic             is_iter;
  iter_op_e         iop;
  logic [SHW-1:0]   k_shift;
  logic [SHW-1:0]   amt;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             it_done;
  logic [WIDTH-1:0] it_result;
  logic             it_high;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;

  assign accept = bus.in_valid & bus.in_ready;

  assign cin = (bus.opcode inside {OP_ADDC, OP_ADDCI, OP_ADDCU, OP_ADDCUI}) & flags_r[FLAG_C];
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]);
  assign sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (diff[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    if (bus.b == '0)
      k_shift = SHW'(1);
    else if (bus.b >= WIDTH'(WIDTH))
      k_shift = SHW'(WIDTH);
    else
      k_shift = bus.b[SHW-1:0];
  end

  always_comb begin
    res_nx  = result_r;
    flg_nx  = flags_r;
    is_iter = 1'b0;
    iop     = IT_SHL;
    amt     = k_shift;
    case (bus.opcode)
      OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI: begin
        res_nx         = sum[WIDTH-1:0];
        flg_nx         = '0;
        flg_nx[FLAG_F] = add_ovf;
        flg_nx[FLAG_Z] = (sum[WIDTH-1:0] == '0);
      end
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
        res_nx         = sum[WIDTH-1:0];
        flg_nx         = '0;
        flg_nx[FLAG_C] = sum[WIDTH];
        flg_nx[FLAG_Z] = (sum[WIDTH-1:0] == '0);
      end
      OP_SUB, OP_SUBI: begin
        res_nx         = diff[WIDTH-1:0];
        flg_nx         = '0;
        flg_nx[FLAG_F] = sub_ovf;
        flg_nx[FLAG_Z] = (diff[WIDTH-1:0] == '0);
      end
      OP_CMP, OP_CMPI: begin
        flg_nx         = '0;
        flg_nx[FLAG_Z] = (bus.a == bus.b);
        flg_nx[FLAG_N] = ($signed(bus.a) < $signed(bus.b));
        flg_nx[FLAG_L] = (bus.a < bus.b);
      end
      OP_CMPU: begin
        flg_nx         = '0;
        flg_nx[FLAG_Z] = (bus.a == bus.b);
        flg_nx[FLAG_L] = (bus.a < bus.b);
      end
      OP_AND: begin res_nx = bus.a & bus.b; flg_nx = '0; end
      OP_OR:  begin res_nx = bus.a | bus.b; flg_nx = '0; end
      OP_XOR: begin res_nx = bus.a ^ bus.b; flg_nx = '0; end
      OP_NOT: begin res_nx = ~bus.a;        flg_nx = '0; end
      OP_LSH, OP_LSHI, OP_ALSH: begin is_iter = 1'b1; iop = IT_SHL; end
      OP_RSH:                   begin is_iter = 1'b1; iop = IT_SHR; end
      OP_RSHI, OP_ARSH:         begin is_iter = 1'b1; iop = IT_SAR; end
      OP_MUL: begin
        is_iter = 1'b1;
        iop     = IT_MUL;
        amt     = SHW'(WIDTH);
      end
      OP_NOP: ;
      default: begin
        res_nx = '0;
        flg_nx = '0;
      end
    endcase
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (it_result == '0);
    mul_flags[FLAG_C] = it_high;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_iter) state_nx = ITER;
      ITER:    if (it_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= '0;
      flags_r     <= '0;
      out_valid_r <= 1'b0;
      mul_pend    <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (accept && !is_iter) begin
        result_r    <= res_nx;
        flags_r     <= flg_nx;
        out_valid_r <= 1'b1;
      end else if (accept) begin
        mul_pend <= (iop == IT_MUL);
      end else if (state == ITER && it_done) begin
        result_r    <= it_result;
        out_valid_r <= 1'b1;
        if (mul_pend) flags_r <= mul_flags;
      end
    end
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept & is_iter),
    .op      (iop),
    .amount  (amt),
    .a       (bus.a),
    .b       (bus.b),
    .done    (it_done),
    .result  (it_result),
    .high_nz (it_high)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int FZ = 4;
  localparam int FC = 3;
  localparam int FF = 2;
  localparam int FL = 1;
  localparam int FN = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_res = '0;
  logic [4:0]   exp_psr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operands, updates expected result/PSR.
  task automatic model_op(input logic [7:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat);
    int unsigned s;
    int unsigned cin;
    int unsigned k;
    longint p;
    logic [W-1:0] r;
    logic [4:0] f;
    logic signed [W-1:0] sa;
    r = exp_res;
    f = exp_psr;
    lat = 1;
    cin = 0;
    if (op == OP_ADDC || op == OP_ADDCI || op == OP_ADDCU || op == OP_ADDCUI)
      cin = 32'(exp_psr[FC]);
    s = 32'(av) + 32'(bv) + cin;
    k = (bv == 0) ? 1 : ((32'(bv) > W) ? W : 32'(bv));
    case (op)
      OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI: begin
        r = W'(s); f = '0;
        f[FF] = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
        f[FZ] = (r == 0);
      end
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
        r = W'(s); f = '0;
        f[FC] = ((s >> W) != 0);
        f[FZ] = (r == 0);
      end
      OP_SUB, OP_SUBI: begin
        r = W'(int'(av) - int'(bv)); f = '0;
        f[FF] = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
        f[FZ] = (r == 0);
      end
      OP_CMP, OP_CMPI, OP_CMPU: begin
        f = '0;
        f[FZ] = (av == bv);
        f[FL] = (av < bv);
        if (op != OP_CMPU) f[FN] = ($signed(av) < $signed(bv));
      end
      OP_AND: begin r = av & bv; f = '0; end
      OP_OR:  begin r = av | bv; f = '0; end
      OP_XOR: begin r = av ^ bv; f = '0; end
      OP_NOT: begin r = ~av;     f = '0; end
      OP_LSH, OP_LSHI, OP_ALSH: begin
        p = longint'(av) << k; r = W'(p); lat = int'(k) + 1;
      end
      OP_RSH: begin r = av >> k; lat = int'(k) + 1; end
      OP_RSHI, OP_ARSH: begin sa = av; r = sa >>> k; lat = int'(k) + 1; end
      OP_MUL: begin
        p = longint'(av) * longint'(bv);
        r = W'(p); f = '0;
        f[FZ] = (r == 0);
        f[FC] = ((p >> W) != 0);
        lat = W + 1;
      end
      OP_NOP: ;
      default: begin r = '0; f = '0; end
    endcase
    exp_res = r;
    exp_psr = f;
  endtask

  task automatic run_op(input logic [7:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit noise);
    int lat;
    int n;
    int low;
    bit seen;
    @(negedge clk);
    check("ready_pre", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = av;
    bus.b        = bv;
    model_op(op, av, bv, lat);
    @(negedge clk);
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    n = 1; low = 0; seen = 0;
    while (n <= 40) begin
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin seen = 1; break; end
      if (!bus.in_ready) begin
        low++;
        if (noise) begin
          bus.in_valid = 1'b1;
          bus.opcode   = 8'($urandom_range(0, 31));
          bus.a        = W'($urandom);
          bus.b        = W'($urandom);
        end
      end
      @(negedge clk);
      n++;
    end
    check($sformatf("done op%0h", op), 32'(seen), 32'd1);
    check($sformatf("latency op%0h", op), 32'(n), 32'(lat));
    check($sformatf("busy op%0h", op), 32'(low), 32'(lat - 1));
    check($sformatf("result op%0h", op), 32'(bus.result), 32'(exp_res));
    check($sformatf("flags op%0h", op), 32'(bus.flags), 32'(exp_psr));
    @(negedge clk);
    check($sformatf("pulse op%0h", op), 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0] op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    bus.in_valid = 1'b0;
    bus.opcode   = OP_NOP;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(negedge clk);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;

    // ADDU carry feeding a back-to-back ADDC
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = OP_ADDU; bus.a = 16'hFFFF; bus.b = 16'h0001;
    model_op(OP_ADDU, 16'hFFFF, 16'h0001, lat);
    @(negedge clk);
    check("addu_valid", 32'(bus.out_valid), 32'd1);
    check("addu_result", 32'(bus.result), 32'h0000);
    check("addu_flags", 32'(bus.flags), 32'b11000);
    check("addu_model", 32'(bus.flags), 32'(exp_psr));
    bus.opcode = OP_ADDC; bus.a = 16'h0000; bus.b = 16'h0000;
    model_op(OP_ADDC, 16'h0000, 16'h0000, lat);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("addc_valid", 32'(bus.out_valid), 32'd1);
    check("addc_result", 32'(bus.result), 32'h0001);
    check("addc_flags", 32'(bus.flags), 32'(exp_psr));
    @(negedge clk);
    check("addc_pulse", 32'(bus.out_valid), 32'd0);

    run_op(OP_ADD,  16'h7FFF, 16'h0001, 0);
    check("add_ovf", 32'(bus.flags), 32'b00100);
    run_op(OP_SUB,  16'h8000, 16'h0001, 0);
    check("sub_ovf", 32'(bus.result), 32'h7FFF);
    run_op(OP_CMP,  16'hFFFE, 16'h0001, 0);
    check("cmp_flags", 32'(bus.flags), 32'b00001);
    check("cmp_result", 32'(bus.result), 32'h7FFF);
    run_op(OP_CMPU, 16'hFFFE, 16'h0001, 0);
    check("cmpu_flags", 32'(bus.flags), 32'b00000);
    run_op(OP_ARSH, 16'h8000, 16'd3, 1);
    check("arsh_result", 32'(bus.result), 32'hF000);
    run_op(OP_LSH,  16'h0003, 16'd0, 0);
    check("lsh0_result", 32'(bus.result), 32'h0006);
    run_op(OP_MUL,  16'h0100, 16'h0100, 1);
    check("mul_flags", 32'(bus.flags), 32'b11000);
    run_op(OP_RSH,  16'h8001, 16'd40, 0);
    run_op(8'h1F,   16'h1234, 16'h5678, 0);

    for (int i = 0; i < 150; i++) begin
      op = 8'($urandom_range(0, 31));
      av = W'($urandom);
      bv = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20)) : W'($urandom);
      run_op(op, av, bv, bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = OP_MUL; bus.a = 16'h0003; bus.b = 16'h0005;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_flags", 32'(bus.flags), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    exp_res = '0;
    exp_psr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("midrst_nopulse", 32'(pulses), 32'd0);
    run_op(OP_ADDU, 16'h0001, 16'h0002, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
